// File: rtl/multicycle_ctrl_if.sv
// Control/status coupling between multicycle_ctrl (master) and the miniRISC data_path (slave).
interface multicycle_ctrl_if #(
  parameter int OPW    = 6,
  parameter int FNW    = 6,
  parameter int ALUOPW = 4,
  parameter int BROPW  = 5
);
  logic [OPW-1:0]    opcode_in;
  logic [FNW-1:0]    func_in;
  logic              dmem_ack;
  logic              ir_en;
  logic              pc_en;
  logic [1:0]        reg_write;
  logic              imm_mux_ctrl;
  logic              alu_mux_ctrl;
  logic [ALUOPW-1:0] alu_op;
  logic              dmem_enable;
  logic              dmem_write_enable;
  logic [1:0]        reg_write_mux_ctrl;
  logic [BROPW-1:0]  br_op;

  modport master (
    input  opcode_in, func_in, dmem_ack,
    output ir_en, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
           dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op
  );

  modport slave (
    output opcode_in, func_in, dmem_ack,
    input  ir_en, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
           dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving every data_path control input.
// Latency FETCH..retire: branch 3, R/ADDI 4, SW 4+w, LW 5+w (w = MEM cycles before dmem_ack).
// Stalls in MEM until dmem_ack, halting with mem_err after MEM_TIMEOUT cycles; run gates only at retire.
module multicycle_ctrl #(
  parameter int OPW         = 6,
  parameter int FNW         = 6,
  parameter int ALUOPW      = 4,
  parameter int BROPW       = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  multicycle_ctrl_if.master dp,
  output logic [2:0]        state_out,
  output logic [CNT_W-1:0]  retired,
  output logic              illegal,
  output logic              mem_err
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BR   = OPW'(4);
  localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};
  localparam int TW      = $clog2(MEM_TIMEOUT + 1);
  // Only the func bits feeding alu_op or br_op need to be held past DECODE.
  localparam int FN_KEEP = (ALUOPW > BROPW - 1) ? ALUOPW : BROPW - 1;

  state_t              state_q, state_d;
  logic [OPW-1:0]      op_q;
  logic [FN_KEEP-1:0]  fn_q;
  logic [TW-1:0]       tmo_q;
  logic                retire;
  logic                legal_in, halt_in;
  logic                is_r, is_addi, is_lw, is_sw, is_br;
  logic [ALUOPW-1:0]   dec_alu_op;
  logic                dec_alu_mux, dec_imm;
  logic [1:0]          dec_rwmux, dec_dest;

  assign legal_in  = dp.opcode_in inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BR, OP_HALT};
  assign halt_in   = (dp.opcode_in == OP_HALT);
  assign is_r      = (op_q == OP_R);
  assign is_addi   = (op_q == OP_ADDI);
  assign is_lw     = (op_q == OP_LW);
  assign is_sw     = (op_q == OP_SW);
  assign is_br     = (op_q == OP_BR);
  assign state_out = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      tmo_q   <= '0;
      retired <= '0;
      illegal <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= dp.opcode_in;
        fn_q <= dp.func_in[FN_KEEP-1:0];
        if (!legal_in) illegal <= 1'b1;
      end
      // Held at zero outside MEM, so every MEM entry starts a fresh count.
      tmo_q <= (state_q == S_MEM) ? tmo_q + 1'b1 : '0;
      if (state_q == S_MEM && state_d == S_HALT) mem_err <= 1'b1;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    dec_alu_op  = '0;
    dec_alu_mux = 1'b0;
    dec_imm     = 1'b0;
    dec_rwmux   = 2'b00;
    dec_dest    = 2'b00;
    if (is_r) begin
      dec_alu_op = fn_q[ALUOPW-1:0];
      dec_rwmux  = 2'b10;
      dec_dest   = 2'b01;
    end
    if (is_addi) begin
      dec_alu_mux = 1'b1;
      dec_rwmux   = 2'b10;
      dec_dest    = 2'b01;
    end
    if (is_lw) begin
      dec_alu_mux = 1'b1;
      dec_imm     = 1'b1;
      dec_rwmux   = 2'b01;
      dec_dest    = 2'b10;
    end
    if (is_sw) begin
      dec_alu_mux = 1'b1;
      dec_imm     = 1'b1;
    end
  end

  always_comb begin
    state_d                  = state_q;
    retire                   = 1'b0;
    dp.ir_en                 = 1'b0;
    dp.reg_write             = 2'b00;
    dp.imm_mux_ctrl          = 1'b0;
    dp.alu_mux_ctrl          = 1'b0;
    dp.alu_op                = '0;
    dp.dmem_enable           = 1'b0;
    dp.dmem_write_enable     = 1'b0;
    dp.reg_write_mux_ctrl    = 2'b00;
    dp.br_op                 = '0;
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      dp.alu_op             = dec_alu_op;
      dp.alu_mux_ctrl       = dec_alu_mux;
      dp.imm_mux_ctrl       = dec_imm;
      dp.reg_write_mux_ctrl = dec_rwmux;
    end
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        dp.ir_en = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: state_d = (!legal_in || halt_in) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_br) begin
          dp.br_op = {1'b1, fn_q[BROPW-2:0]};
          retire   = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dp.dmem_enable       = 1'b1;
        dp.dmem_write_enable = is_sw;
        // An ack on the final allowed cycle still completes the access.
        if (dp.dmem_ack) begin
          if (is_sw) retire = 1'b1;
          else       state_d = S_WB;
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        dp.reg_write = dec_dest;
        retire       = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
    dp.pc_en = retire;
  end
endmodule
